// File: rtl/huffman_pkg.sv
// Shared Huffman types and constants, used by both the decoder and the encoder.
//   NUM_SYMS / SYM_W / MAX_CODE_LEN : table depth, symbol width, longest legal code
//   IDX_W / LEN_W                   : derived index and code-length field widths
//   huff_entry_t                    : one code-table entry {sym, code, len}
//   dec_state_t                     : decoder FSM states
//   code_mask()                     : right-aligned mask covering the low len bits
package huffman_pkg;

    localparam int NUM_SYMS     = 16;
    localparam int SYM_W        = 8;
    localparam int MAX_CODE_LEN = 9;
    localparam int IDX_W        = $clog2(NUM_SYMS);
    localparam int LEN_W        = $clog2(MAX_CODE_LEN + 1);

    typedef struct packed {
        logic [SYM_W-1:0]        sym;
        logic [MAX_CODE_LEN-1:0] code;
        logic [LEN_W-1:0]        len;
    } huff_entry_t;

    typedef enum logic [1:0] {
        SHIFT  = 2'd0,
        SEARCH = 2'd1,
        EMIT   = 2'd2,
        ERROR  = 2'd3
    } dec_state_t;

    // One extra bit of headroom so a full-length code yields an all-ones mask.
    function automatic logic [MAX_CODE_LEN-1:0] code_mask(input logic [LEN_W-1:0] len);
        logic [MAX_CODE_LEN:0] one_hot;
        logic [MAX_CODE_LEN:0] full;
        one_hot   = {{MAX_CODE_LEN{1'b0}}, 1'b1} << len;
        full      = one_hot - {{MAX_CODE_LEN{1'b0}}, 1'b1};
        code_mask = full[MAX_CODE_LEN-1:0];
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Huffman decoder bus bundle: table write port, serial bit input and
// symbol output handshake, plus status flags.
//   master : drives table writes, bits and sym_ready (producer/consumer side)
//   slave  : the decoder itself
interface huffman_decoder_if;
    import huffman_pkg::*;

    logic                    tbl_we;
    logic [IDX_W-1:0]        tbl_idx;
    logic [SYM_W-1:0]        tbl_sym;
    logic [MAX_CODE_LEN-1:0] tbl_code;
    logic [LEN_W-1:0]        tbl_len;
    logic                    bit_valid;
    logic                    bit_in;
    logic                    bit_ready;
    logic                    sym_valid;
    logic [SYM_W-1:0]        sym_data;
    logic [LEN_W-1:0]        sym_len;
    logic                    sym_ready;
    logic                    busy;
    logic                    err;

    modport master (
        output tbl_we, tbl_idx, tbl_sym, tbl_code, tbl_len,
        output bit_valid, bit_in, sym_ready,
        input  bit_ready, sym_valid, sym_data, sym_len, busy, err
    );

    modport slave (
        input  tbl_we, tbl_idx, tbl_sym, tbl_code, tbl_len,
        input  bit_valid, bit_in, sym_ready,
        output bit_ready, sym_valid, sym_data, sym_len, busy, err
    );

endinterface

// File: rtl/huffman_code_table.sv
// Huffman code table: NUM_SYMS entries, one write port, one combinational
// read port. Reset clears every entry's length, marking it invalid; symbol
// and code fields need no reset because a zero length never matches.
//   clk, reset : clock, synchronous active-high reset
//   we         : write strobe (already qualified by the caller)
//   wr_idx     : entry written
//   wr_entry   : new {sym, code, len}
//   rd_idx     : entry read
//   rd_entry   : entry at rd_idx
module huffman_code_table
    import huffman_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  huff_entry_t      wr_entry,
    input  logic [IDX_W-1:0] rd_idx,
    output huff_entry_t      rd_entry
);

    huff_entry_t table_r [NUM_SYMS];

    // Entry storage: reset invalidates all entries, otherwise accept writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SYMS; i++) begin
                table_r[i].len <= {LEN_W{1'b0}};
            end
        end else if (we) begin
            table_r[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = table_r[rd_idx];

endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder top: accumulates an MSB-first bitstream and, after every
// bit, scans the code table one entry per cycle for a code of the current
// length. A hit is emitted over sym_valid/sym_ready; a miss at the longest
// legal length raises a sticky err and halts until reset.
//   clk, reset : clock, synchronous active-high reset
//   dif        : huffman_decoder_if slave (table port, bit input, symbol output,
//                busy and err flags)
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    huffman_decoder_if.slave  dif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYMS - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_CODE_LEN);

    dec_state_t              state_r,     state_s;
    logic [MAX_CODE_LEN-1:0] acc_r,       acc_s;
    logic [LEN_W-1:0]        cur_len_r,   cur_len_s;
    logic [IDX_W-1:0]        idx_r,       idx_s;
    logic                    sym_valid_r, sym_valid_s;
    logic [SYM_W-1:0]        sym_data_r,  sym_data_s;
    logic [LEN_W-1:0]        sym_len_r,   sym_len_s;
    logic                    err_r,       err_s;

    huff_entry_t             wr_entry_s;
    huff_entry_t             entry_s;
    logic                    busy_s;
    logic                    tbl_we_s;
    logic                    hit_s;

    // A partially received code counts as busy even while waiting in SHIFT.
    assign busy_s   = (state_r != SHIFT) || (cur_len_r != {LEN_W{1'b0}});
    assign tbl_we_s = dif.tbl_we && !busy_s && (state_r != ERROR);

    assign wr_entry_s.sym  = dif.tbl_sym;
    assign wr_entry_s.code = dif.tbl_code;
    assign wr_entry_s.len  = dif.tbl_len;

    huffman_code_table u_table (
        .clk      (clk),
        .reset    (reset),
        .we       (tbl_we_s),
        .wr_idx   (dif.tbl_idx),
        .wr_entry (wr_entry_s),
        .rd_idx   (idx_r),
        .rd_entry (entry_s)
    );

    // Only the low cur_len bits of the stored code take part in the match.
    assign hit_s = (entry_s.len == cur_len_r) &&
                   (((entry_s.code ^ acc_r) & code_mask(cur_len_r)) == {MAX_CODE_LEN{1'b0}});

    // Next-state and datapath updates for the SHIFT/SEARCH/EMIT/ERROR FSM.
    always_comb begin
        state_s     = state_r;
        acc_s       = acc_r;
        cur_len_s   = cur_len_r;
        idx_s       = idx_r;
        sym_valid_s = sym_valid_r;
        sym_data_s  = sym_data_r;
        sym_len_s   = sym_len_r;
        err_s       = err_r;
        case (state_r)
            SHIFT: begin
                if (dif.bit_valid) begin
                    acc_s     = {acc_r[MAX_CODE_LEN-2:0], dif.bit_in};
                    cur_len_s = cur_len_r + LEN_W'(1'b1);
                    idx_s     = {IDX_W{1'b0}};
                    state_s   = SEARCH;
                end else begin
                    state_s   = SHIFT;
                end
            end
            SEARCH: begin
                if (hit_s) begin
                    sym_data_s  = entry_s.sym;
                    sym_len_s   = entry_s.len;
                    sym_valid_s = 1'b1;
                    state_s     = EMIT;
                end else if (idx_r != LAST_IDX) begin
                    idx_s       = idx_r + IDX_W'(1'b1);
                end else if (cur_len_r == MAX_LEN) begin
                    err_s       = 1'b1;
                    state_s     = ERROR;
                end else begin
                    // Code still incomplete: keep acc/cur_len and fetch another bit.
                    state_s     = SHIFT;
                end
            end
            EMIT: begin
                if (sym_valid_r && dif.sym_ready) begin
                    sym_valid_s = 1'b0;
                    acc_s       = {MAX_CODE_LEN{1'b0}};
                    cur_len_s   = {LEN_W{1'b0}};
                    state_s     = SHIFT;
                end else begin
                    state_s     = EMIT;
                end
            end
            ERROR: begin
                sym_valid_s = 1'b0;
                err_s       = 1'b1;
                state_s     = ERROR;
            end
            default: begin
                state_s     = SHIFT;
            end
        endcase
    end

    // State and datapath registers; reset overrides any search or emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= SHIFT;
            acc_r       <= {MAX_CODE_LEN{1'b0}};
            cur_len_r   <= {LEN_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            sym_valid_r <= 1'b0;
            sym_data_r  <= {SYM_W{1'b0}};
            sym_len_r   <= {LEN_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cur_len_r   <= cur_len_s;
            idx_r       <= idx_s;
            sym_valid_r <= sym_valid_s;
            sym_data_r  <= sym_data_s;
            sym_len_r   <= sym_len_s;
            err_r       <= err_s;
        end
    end

    assign dif.bit_ready = (state_r == SHIFT);
    assign dif.sym_valid = sym_valid_r;
    assign dif.sym_data  = sym_data_r;
    assign dif.sym_len   = sym_len_r;
    assign dif.busy      = busy_s;
    assign dif.err       = err_r;

endmodule
